butterfly_pair_stage: RTL and testbench



---
 rtl/butterfly_pair_stage.sv | 118 +++++++++++
 tb/tb_butterfly_pair_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pair_stage.sv
// Radix-2 butterfly stage: pops sample pairs (A then B) from a FIFO read port
// and presents sum = A+B, diff = A-B on a valid/ready output with a pair counter.
module butterfly_pair_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic                  flush,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic [DATA_WIDTH:0]   out_diff,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  pair_cnt,
  output logic [1:0]            dbg_state
);

  // Output handshake: a result transfers at a posedge where out_valid && out_ready.
  // out_sum/out_diff/out_valid hold stable while out_valid && !out_ready.
  typedef enum logic [1:0] {
    ST_WAIT_A = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH:0]   sum_q;
  logic [DATA_WIDTH:0]   diff_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   b_ext;
  logic [DATA_WIDTH:0]   sum_d;
  logic [DATA_WIDTH:0]   diff_d;
  logic                  handshake;

  // One extra bit of headroom makes both results exact for any signed pair.
  assign a_ext     = {a_q[DATA_WIDTH-1], a_q};
  assign b_ext     = {fifo_data[DATA_WIDTH-1], fifo_data};
  assign sum_d     = a_ext + b_ext;
  assign diff_d    = a_ext - b_ext;
  assign handshake = valid_q && out_ready;

  // The FIFO head is undefined while empty, so a pop is never requested then.
  always_comb begin
    fifo_re = 1'b0;
    if (rst && !fifo_empty && !flush) begin
      case (state_q)
        ST_WAIT_A: fifo_re = 1'b1;
        ST_WAIT_B: fifo_re = 1'b1;
        ST_OUT:    fifo_re = out_ready;
        default:   fifo_re = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_WAIT_A;
      a_q     <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_WAIT_A: begin
          if (fifo_re) begin
            a_q     <= fifo_data;
            state_q <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (fifo_re) begin
            sum_q   <= sum_d;
            diff_q  <= diff_d;
            valid_q <= 1'b1;
            state_q <= ST_OUT;
          end else if (flush) begin
            a_q     <= '0;
            state_q <= ST_WAIT_A;
          end
        end
        ST_OUT: begin
          // A pop here is the next pair's A, overlapping the handshake.
          if (handshake) begin
            cnt_q   <= cnt_q + CNT_ONE;
            valid_q <= 1'b0;
            if (fifo_re) begin
              a_q     <= fifo_data;
              state_q <= ST_WAIT_B;
            end else begin
              state_q <= ST_WAIT_A;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign out_sum   = sum_q;
  assign out_diff  = diff_q;
  assign out_valid = valid_q;
  assign pair_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_butterfly_pair_stage.sv
// Bench for butterfly_pair_stage: FIFO model feeding the stage, a pairing
// reference model with an expected-result queue, and a negedge monitor.
module tb_butterfly_pair_stage;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_re;
  logic          flush = 1'b0;
  logic [DW:0]   out_sum;
  logic [DW:0]   out_diff;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] pair_cnt;
  logic [1:0]    dbg_state;

  butterfly_pair_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .flush(flush), .out_sum(out_sum), .out_diff(out_diff),
    .out_valid(out_valid), .out_ready(out_ready), .pair_cnt(pair_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- state ----------------
  logic [DW-1:0]     src_q[$];
  logic [2*DW+1:0]   exp_q[$];
  int                n_checks = 0;
  int                n_pass = 0;
  bit                mon_en = 1'b0;
  bit                pop_seen = 1'b0;
  bit                have_a = 1'b0;
  logic [DW-1:0]     a_val = '0;
  int                exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference butterfly with plain integer arithmetic, truncated to DW+1 bits.
  function automatic logic [2*DW+1:0] butterfly(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb, s, d;
    sa = $signed(a);
    sb = $signed(b);
    s = sa + sb;
    d = sa - sb;
    return {s[DW:0], d[DW:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic refresh();
    fifo_empty = (src_q.size() == 0);
    fifo_data  = fifo_empty ? DW'($urandom) : src_q[0];
  endtask

  task automatic push(input logic [DW-1:0] v);
    src_q.push_back(v);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen && src_q.size() != 0) void'(src_q.pop_front());
    refresh();
    #1;
  endtask

  task automatic wait_valid(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (out_valid) found = 1'b1;
      else step();
    end
    if (!found) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW:0] es, input logic [DW:0] ed);
    push(a);
    push(b);
    wait_valid(10);
    check("pair_sum", out_sum, es);
    check("pair_diff", out_diff, ed);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit exp_re;
    exp_re = rst && !fifo_empty && !flush && (exp_q.size() == 0 || out_ready);
    if (mon_en) begin
      check("fifo_re", fifo_re, exp_re);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        check("sb_sum", out_sum, exp_q[0][2*DW+1:DW+1]);
        check("sb_diff", out_diff, exp_q[0][DW:0]);
      end
      check("pair_cnt", pair_cnt, exp_cnt % (1 << CW));
      // Advance the model to what the coming posedge should produce.
      if (!rst) begin
        exp_q.delete();
        have_a  = 1'b0;
        exp_cnt = 0;
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          void'(exp_q.pop_front());
          exp_cnt++;
        end
        if (exp_re) begin
          if (have_a) begin
            exp_q.push_back(butterfly(a_val, fifo_data));
            have_a = 1'b0;
          end else begin
            a_val  = fifo_data;
            have_a = 1'b1;
          end
        end else if (flush) begin
          have_a = 1'b0;
        end
      end
    end
    pop_seen = fifo_re;
  end

  // ---------------- stimulus ----------------
  logic [DW:0] held_sum, held_diff;

  initial begin
    // Reset with a non-empty FIFO.
    rst = 1'b0;
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step();
    mon_en = 1'b1;
    check("rst_re", fifo_re, 1'b0);
    step();
    check("rst_re2", fifo_re, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_cnt", pair_cnt, 0);
    check("rst_sum", out_sum, 0);
    check("rst_diff", out_diff, 0);
    src_q.delete();
    refresh();
    rst = 1'b1;

    // Basic pair 05, 03.
    push(8'h05); push(8'h03);
    #1;
    check("re_a", fifo_re, 1'b1);
    step();
    check("re_b", fifo_re, 1'b1);
    step();
    check("lat_valid", out_valid, 1'b1);
    check("basic_sum", out_sum, 9'h008);
    check("basic_diff", out_diff, 9'h002);
    step();
    check("basic_cnt", pair_cnt, 1);
    check("basic_valid_clr", out_valid, 1'b0);

    // Sign / overflow corners.
    run_pair(8'h7F, 8'h80, 9'h1FF, 9'h0FF);
    run_pair(8'h80, 8'h80, 9'h100, 9'h000);

    // Backpressure with samples queued behind the pending result.
    out_ready = 1'b0;
    push(8'h22); push(8'h11); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_valid(10);
    held_sum  = out_sum;
    held_diff = out_diff;
    check("bp_sum", out_sum, 9'h033);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", out_valid, 1'b1);
      check("bp_hold_sum", out_sum, held_sum);
      check("bp_hold_diff", out_diff, held_diff);
      check("bp_no_pop", fifo_re, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_hs_pop", fifo_re, 1'b1);
    step();
    check("bp_after_valid", out_valid, 1'b0);
    for (int i = 0; i < 12; i++) step();
    check("bp_drained", src_q.size(), 0);

    // Empty gap between the halves of a pair.
    push(8'h10);
    repeat (6) step();
    push(8'hF0);
    wait_valid(10);
    check("gap_sum", out_sum, 9'h000);
    check("gap_diff", out_diff, 9'h020);
    step();

    // Flush discards a held A.
    push(8'h10);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    push(8'h01); push(8'h02);
    wait_valid(10);
    check("flush_sum", out_sum, 9'h003);
    check("flush_diff", out_diff, 9'h1FF);
    step();

    // Randomized traffic with backpressure, flushes, empties and rare resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && src_q.size() < 8) push(DW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("rand_drain", exp_q.size(), 0);

    // Counter wrap and full throughput: 17 pairs back to back.
    rst = 1'b0;
    step();
    src_q.delete();
    refresh();
    rst = 1'b1;
    for (int i = 0; i < 34; i++) push(DW'($urandom));
    repeat (35) step();
    check("wrap_cnt", pair_cnt, 1);
    check("wrap_fifo_empty", src_q.size(), 0);
    check("wrap_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
